controle_robo: RTL and testbench
================================

CONTROLE_ROBO -- requirements
Module: controle_robo

Interface
REQ-001 Parameter RM_CYCLES, default 4: number of cycles remover is held per removal.
REQ-002 Parameter MAX_STEPS, default 200: advance count at which the run ends.
REQ-003 Parameter MAX_TURNS, default 4: consecutive turns without an advance that declare the robot stuck.
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request, sampled only in IDLE and HALT.
REQ-007 head  input  1  wall directly ahead.
REQ-008 left  input  1  wall on left; latched and exported only, no decision use.
REQ-009 under  input  1  dirt under robot.
REQ-010 barreira  input  1  obstacle ahead; blocks advance like head.
REQ-011 en_sense  output  1  one-cycle strobe; sensors are captured this cycle.
REQ-012 avancar  output  1  one-cycle advance command to the orientation/advance datapath.
REQ-013 girar  output  1  one-cycle turn command.
REQ-014 remover  output  1  removal command, held RM_CYCLES cycles.
REQ-015 en_map  output  1  one-cycle map-update strobe.
REQ-016 busy  output  1  high in every state except IDLE and HALT.
REQ-017 stuck  output  1  sticky flag: halted after MAX_TURNS consecutive turns.
REQ-018 done  output  1  sticky flag: halted after MAX_STEPS advances.
REQ-019 passos  output  8  advance counter.
REQ-020 estado  output  3  current FSM state encoding.

Function
REQ-021 The FSM SHALL have states IDLE=0, SENSE=1, DECIDE=2, ACT=3, MAP=4, REMOVE=5, HALT=6; code 7 SHALL recover to IDLE.
REQ-022 IDLE: start=1 -> SENSE and clear passos, turn counter, stuck and done; otherwise stay in IDLE.
REQ-023 SENSE: assert en_sense; register head, left, under and barreira at the end of the cycle; -> DECIDE.
REQ-024 DECIDE uses registered sensors with priority under=1 and barreira=0 -> REMOVE, else head=0 and barreira=0 -> ACT(advance), else -> ACT(turn).
REQ-025 ACT: assert exactly one of avancar or girar for one cycle; -> MAP.
REQ-026 On an advance, passos SHALL increment (saturating at 255) and the turn counter SHALL clear; on a turn, the turn counter SHALL increment.
REQ-027 MAP: assert en_map for one cycle.
REQ-028 From MAP, the FSM SHALL go to HALT with done=1 if passos=MAX_STEPS, else to HALT with stuck=1 if the turn counter=MAX_TURNS, else to SENSE.
REQ-029 If both halt conditions hold in the same MAP cycle, done SHALL take priority and stuck SHALL stay 0.
REQ-030 REMOVE: hold remover high for exactly RM_CYCLES consecutive cycles using a down-counter, then -> SENSE; passos and the turn counter are unchanged.
REQ-031 A normal move SHALL take 4 cycles (SENSE, DECIDE, ACT, MAP); a removal SHALL take 2+RM_CYCLES cycles before the next SENSE.
REQ-032 HALT: all command strobes and busy SHALL be 0; stuck/done hold.
REQ-033 HALT -> IDLE only when start=0, so a new run requires start to go low, then high.
REQ-034 start changes while busy=1 SHALL be ignored.
REQ-035 Sensor input changes outside SENSE SHALL have no effect on decisions.
REQ-036 avancar, girar, remover, en_sense and en_map SHALL be registered outputs.
REQ-037 At most one of avancar, girar, remover, en_sense and en_map SHALL be high in any cycle.

Reset
REQ-038 reset=0 SHALL immediately force state IDLE.
REQ-039 reset=0 SHALL immediately zero all outputs, passos, the turn counter, the removal counter and the sensor registers, including mid-REMOVE.
REQ-040 The first SENSE after reset release SHALL occur one cycle after start is sampled high in IDLE.

Verification
REQ-041 Open field: start=1, head=0, under=0, barreira=0 -> repeating en_sense, -, avancar, en_map pattern every 4 cycles; done=1, passos=200 and busy=0 after 800 cycles.
REQ-042 Boxed in: head=1 constantly -> four girar pulses 4 cycles apart, then HALT with stuck=1, passos=0.
REQ-043 Dirt: under=1 at the first SENSE, then 0 -> remover high exactly 4 cycles starting 2 cycles after en_sense, then SENSE, then avancar.
REQ-044 Barreira: under=1 with barreira=1 -> girar, no remover; head=0 with barreira=1 -> girar, no avancar.
REQ-045 Reset mid-REMOVE: assert reset on the 2nd remover cycle -> remover=0 and estado=0 without waiting for a clock edge; after release with start=1, SENSE follows next cycle.
REQ-046 Re-arm: in HALT with start held 1, the FSM stays in HALT; start=0 -> IDLE; start=1 -> flags cleared and a new run begins.

Source files
------------

// File: rtl/controle_robo.sv
// Cleaning-robot motion controller.
// Sequences sense -> decide -> act -> map moves, runs timed dirt removal, and
// halts when the advance budget is used up or the robot keeps turning in place.
module controle_robo #(
    parameter int unsigned RM_CYCLES = 4,   // cycles remover is held per removal
    parameter int unsigned MAX_STEPS = 200, // advance count that ends the run
    parameter int unsigned MAX_TURNS = 4    // consecutive turns that mean "stuck"
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       head,
    input  logic       left,
    input  logic       under,
    input  logic       barreira,
    output logic       en_sense,
    output logic       avancar,
    output logic       girar,
    output logic       remover,
    output logic       en_map,
    output logic       busy,
    output logic       stuck,
    output logic       done,
    output logic [7:0] passos,
    output logic [2:0] estado,
    output logic       left_reg
);

    // Removal down-counter width; it only ever holds RM_CYCLES-1 down to 0.
    localparam int unsigned RmW = (RM_CYCLES > 2) ? $clog2(RM_CYCLES) : 1;

    localparam logic [RmW-1:0] RmLoad   = RmW'(RM_CYCLES - 1);
    localparam logic [7:0]     MaxSteps = 8'(MAX_STEPS);
    localparam logic [7:0]     MaxTurns = 8'(MAX_TURNS);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StSense  = 3'd1,
        StDecide = 3'd2,
        StAct    = 3'd3,
        StMap    = 3'd4,
        StRemove = 3'd5,
        StHalt   = 3'd6
    } state_t;

    state_t         state;
    logic [7:0]     turns;
    logic [RmW-1:0] rm_cnt;

    // Sensor snapshot taken at the end of SENSE; DECIDE only looks at these,
    // so sensor activity at any other time cannot steer the robot.
    logic head_q;
    logic under_q;
    logic barreira_q;

    // Whole controller: state, counters, flags and command strobes.
    // Every command is set on the edge that enters its state, so each strobe is
    // a flop output aligned exactly with the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= StIdle;
            turns      <= '0;
            rm_cnt     <= '0;
            passos     <= '0;
            stuck      <= 1'b0;
            done       <= 1'b0;
            en_sense   <= 1'b0;
            avancar    <= 1'b0;
            girar      <= 1'b0;
            remover    <= 1'b0;
            en_map     <= 1'b0;
            head_q     <= 1'b0;
            under_q    <= 1'b0;
            barreira_q <= 1'b0;
            left_reg   <= 1'b0;
        end else begin
            // Single-cycle strobes fall back to zero unless re-armed below.
            en_sense <= 1'b0;
            avancar  <= 1'b0;
            girar    <= 1'b0;
            en_map   <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state    <= StSense;
                        en_sense <= 1'b1;
                        passos   <= '0;
                        turns    <= '0;
                        stuck    <= 1'b0;
                        done     <= 1'b0;
                    end
                end

                StSense: begin
                    head_q     <= head;
                    under_q    <= under;
                    barreira_q <= barreira;
                    left_reg   <= left;
                    state      <= StDecide;
                end

                StDecide: begin
                    if (under_q && !barreira_q) begin
                        // Dirt wins unless an obstacle is in the way.
                        state   <= StRemove;
                        remover <= 1'b1;
                        rm_cnt  <= RmLoad;
                    end else if (!head_q && !barreira_q) begin
                        state   <= StAct;
                        avancar <= 1'b1;
                        turns   <= '0;
                        if (passos != 8'hFF) begin
                            passos <= passos + 8'd1;
                        end
                    end else begin
                        state <= StAct;
                        girar <= 1'b1;
                        if (turns != 8'hFF) begin
                            turns <= turns + 8'd1;
                        end
                    end
                end

                StAct: begin
                    state  <= StMap;
                    en_map <= 1'b1;
                end

                StMap: begin
                    // done outranks stuck when both limits are hit together.
                    if (passos == MaxSteps) begin
                        state <= StHalt;
                        done  <= 1'b1;
                    end else if (turns == MaxTurns) begin
                        state <= StHalt;
                        stuck <= 1'b1;
                    end else begin
                        state    <= StSense;
                        en_sense <= 1'b1;
                    end
                end

                StRemove: begin
                    if (rm_cnt == '0) begin
                        state    <= StSense;
                        remover  <= 1'b0;
                        en_sense <= 1'b1;
                    end else begin
                        rm_cnt <= rm_cnt - RmW'(1);
                    end
                end

                StHalt: begin
                    // Wait for start to drop so a held start cannot relaunch.
                    if (!start) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state   <= StIdle;
                    remover <= 1'b0;
                end
            endcase
        end
    end

    // Busy covers every working state; decoded from the state flop.
    always_comb begin
        busy = (state != StIdle) && (state != StHalt);
    end

    // State code exported for observation.
    always_comb begin
        estado = state;
    end

endmodule

// File: tb/tb_controle_robo.sv
// Directed self-checking bench for controle_robo (default parameters).
module tb_controle_robo;

    logic       clock;
    logic       reset;
    logic       start;
    logic       head;
    logic       left;
    logic       under;
    logic       barreira;
    logic       en_sense;
    logic       avancar;
    logic       girar;
    logic       remover;
    logic       en_map;
    logic       busy;
    logic       stuck;
    logic       done;
    logic [7:0] passos;
    logic [2:0] estado;
    logic       left_reg;

    int n_cmp;
    int n_err;

    controle_robo dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .head     (head),
        .left     (left),
        .under    (under),
        .barreira (barreira),
        .en_sense (en_sense),
        .avancar  (avancar),
        .girar    (girar),
        .remover  (remover),
        .en_map   (en_map),
        .busy     (busy),
        .stuck    (stuck),
        .done     (done),
        .passos   (passos),
        .estado   (estado),
        .left_reg (left_reg)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Strobe vector in fixed order {en_sense, avancar, girar, remover, en_map}.
    function automatic logic [4:0] strobes();
        return {en_sense, avancar, girar, remover, en_map};
    endfunction

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Asynchronous reset, released just after an edge with quiet inputs.
    task automatic apply_reset();
        reset    = 1'b0;
        start    = 1'b0;
        head     = 1'b0;
        left     = 1'b0;
        under    = 1'b0;
        barreira = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        start    = 1'b1;
        head     = 1'b0;
        left     = 1'b0;
        under    = 1'b0;
        barreira = 1'b0;
        tick();
        n_cmp++;
        if (strobes() !== 5'b00000) begin
            n_err++;
            $display("FAIL reset_strobes: got %b want 00000", strobes());
        end
        n_cmp++;
        if (estado !== 3'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got estado=%0d busy=%b want 0/0", estado, busy);
        end
        n_cmp++;
        if (passos !== 8'd0 || stuck !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got passos=%0d stuck=%b done=%b want 0/0/0",
                     passos, stuck, done);
        end
        start = 1'b0;
        tick();
        reset = 1'b1;
        // Start low: IDLE must hold.
        tick();
        n_cmp++;
        if (estado !== 3'd0) begin
            n_err++;
            $display("FAIL idle_hold: got estado=%0d want 0", estado);
        end
    endtask

    task automatic test_open_field();
        logic [4:0] exp;
        int         ph;
        apply_reset();
        start = 1'b1;
        for (int i = 1; i <= 800; i++) begin
            tick();
            ph = (i - 1) % 4;
            exp = {ph == 0, ph == 2, 1'b0, 1'b0, ph == 3};
            n_cmp++;
            if (strobes() !== exp) begin
                n_err++;
                $display("FAIL open_pattern cycle %0d: got %b want %b", i, strobes(), exp);
            end
        end
        n_cmp++;
        if (estado !== 3'd4 || passos !== 8'd200) begin
            n_err++;
            $display("FAIL open_last_map: got estado=%0d passos=%0d want 4/200", estado, passos);
        end
        tick();
        n_cmp++;
        if (estado !== 3'd6 || done !== 1'b1 || stuck !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL open_halt: got estado=%0d done=%b stuck=%b busy=%b want 6/1/0/0",
                     estado, done, stuck, busy);
        end
        n_cmp++;
        if (passos !== 8'd200) begin
            n_err++;
            $display("FAIL open_passos: got %0d want 200", passos);
        end
        tick();
        n_cmp++;
        if (strobes() !== 5'b00000 || estado !== 3'd6) begin
            n_err++;
            $display("FAIL open_halt_quiet: got %b estado=%0d want 00000/6", strobes(), estado);
        end
    endtask

    task automatic test_boxed_in();
        logic [4:0] exp;
        int         ph;
        apply_reset();
        head  = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            ph = (i - 1) % 4;
            exp = {ph == 0, 1'b0, ph == 2, 1'b0, ph == 3};
            n_cmp++;
            if (strobes() !== exp) begin
                n_err++;
                $display("FAIL boxed_pattern cycle %0d: got %b want %b", i, strobes(), exp);
            end
        end
        tick();
        n_cmp++;
        if (estado !== 3'd6 || stuck !== 1'b1 || done !== 1'b0 || passos !== 8'd0) begin
            n_err++;
            $display("FAIL boxed_halt: got estado=%0d stuck=%b done=%b passos=%0d want 6/1/0/0",
                     estado, stuck, done, passos);
        end
    endtask

    task automatic test_dirt();
        logic [4:0] tbl [10];
        tbl = '{5'b10000, 5'b00000, 5'b00010, 5'b00010, 5'b00010,
                5'b00010, 5'b10000, 5'b00000, 5'b01000, 5'b00001};
        apply_reset();
        under = 1'b1;
        left  = 1'b1;
        start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 2) begin
                under = 1'b0;
                left  = 1'b0;
                n_cmp++;
                if (left_reg !== 1'b1) begin
                    n_err++;
                    $display("FAIL dirt_left_latch: got %b want 1", left_reg);
                end
            end
            n_cmp++;
            if (strobes() !== tbl[i-1]) begin
                n_err++;
                $display("FAIL dirt_seq cycle %0d: got %b want %b", i, strobes(), tbl[i-1]);
            end
            if (i == 6) begin
                n_cmp++;
                if (passos !== 8'd0 || estado !== 3'd5) begin
                    n_err++;
                    $display("FAIL dirt_remove_state: got passos=%0d estado=%0d want 0/5",
                             passos, estado);
                end
            end
        end
        n_cmp++;
        if (passos !== 8'd1) begin
            n_err++;
            $display("FAIL dirt_passos: got %0d want 1", passos);
        end
    endtask

    task automatic test_barreira();
        // Dirt under an obstacle: turn, never remove.
        apply_reset();
        under    = 1'b1;
        barreira = 1'b1;
        start    = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++;
        if (strobes() !== 5'b00100) begin
            n_err++;
            $display("FAIL barr_dirt: got %b want 00100", strobes());
        end
        // Clear path but obstacle: turn. Dropping barreira during DECIDE must not matter.
        apply_reset();
        barreira = 1'b1;
        start    = 1'b1;
        tick();
        tick();
        barreira = 1'b0;
        tick();
        n_cmp++;
        if (strobes() !== 5'b00100) begin
            n_err++;
            $display("FAIL barr_clear: got %b want 00100", strobes());
        end
        n_cmp++;
        if (passos !== 8'd0) begin
            n_err++;
            $display("FAIL barr_passos: got %0d want 0", passos);
        end
    endtask

    task automatic test_reset_mid_remove();
        apply_reset();
        under = 1'b1;
        start = 1'b1;
        tick();
        tick();
        under = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (remover !== 1'b1) begin
            n_err++;
            $display("FAIL rst_rm_pre: got remover=%b want 1", remover);
        end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (remover !== 1'b0 || estado !== 3'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_rm_async: got remover=%b estado=%0d busy=%b want 0/0/0",
                     remover, estado, busy);
        end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (estado !== 3'd1 || en_sense !== 1'b1) begin
            n_err++;
            $display("FAIL rst_rm_restart: got estado=%0d en_sense=%b want 1/1",
                     estado, en_sense);
        end
    endtask

    task automatic test_rearm();
        apply_reset();
        head  = 1'b1;
        start = 1'b1;
        repeat (17) tick();
        repeat (3) tick();
        n_cmp++;
        if (estado !== 3'd6 || stuck !== 1'b1) begin
            n_err++;
            $display("FAIL rearm_hold: got estado=%0d stuck=%b want 6/1", estado, stuck);
        end
        start = 1'b0;
        tick();
        n_cmp++;
        if (estado !== 3'd0 || stuck !== 1'b1 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rearm_idle: got estado=%0d stuck=%b busy=%b want 0/1/0",
                     estado, stuck, busy);
        end
        head  = 1'b0;
        start = 1'b1;
        tick();
        n_cmp++;
        if (estado !== 3'd1 || stuck !== 1'b0 || done !== 1'b0 || en_sense !== 1'b1) begin
            n_err++;
            $display("FAIL rearm_start: got estado=%0d stuck=%b done=%b en_sense=%b want 1/0/0/1",
                     estado, stuck, done, en_sense);
        end
        // start toggling while busy is ignored.
        start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (avancar !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rearm_busy_start: got avancar=%b busy=%b want 1/1", avancar, busy);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_open_field();
        test_boxed_in();
        test_dirt();
        test_barreira();
        test_reset_mid_remove();
        test_rearm();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
